// File: rtl/ctrl_io_cfg_pkg.sv
// ctrl_io_cfg_pkg: shared state encoding and frame sizing for the ctrl_IO config loader
package ctrl_io_cfg_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, COMMIT, ERR} state_t;
    function automatic int num_words(input int bits, input int word_w);
        return (bits + word_w - 1) / word_w;
    endfunction
endpackage

// File: rtl/ctrl_io_cfg_shifter.sv
// ctrl_io_cfg_shifter: word latch, shadow shift register and per-word bit counter
module ctrl_io_cfg_shifter #(
    parameter int NoConfigBits = 12,
    parameter int WORD_W       = 8
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    shift_en,
    input  logic [WORD_W-1:0]       word,
    output logic [NoConfigBits-1:0] shadow,
    output logic                    shift_done
);
    localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    logic [WORD_W-1:0] word_q;
    logic [BW-1:0]     bit_cnt;
    assign shift_done = shift_en && bit_cnt == BW'(WORD_W - 1);
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            shadow  <= '0;
            word_q  <= '0;
            bit_cnt <= '0;
        end else begin
            if (clear) shadow <= '0;
            else if (shift_en) shadow <= {shadow[NoConfigBits-2:0], word_q[WORD_W-1]};
            if (load) begin
                word_q  <= word;
                bit_cnt <= '0;
            end else if (shift_en) begin
                word_q  <= word_q << 1;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ctrl_io_config_loader.sv
// ctrl_io_config_loader: loads a word-stream frame into a shadow register and commits it atomically
module ctrl_io_config_loader
    import ctrl_io_cfg_pkg::*;
#(
    parameter int NoConfigBits = 12,
    parameter int WORD_W       = 8
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic                    cfg_start,
    input  logic [WORD_W-1:0]       cfg_data,
    input  logic                    cfg_valid,
    input  logic                    cfg_last,
    output logic                    cfg_ready,
    output logic [NoConfigBits-1:0] ConfigBits,
    output logic [NoConfigBits-1:0] ConfigBits_N,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int NUM_WORDS = num_words(NoConfigBits, WORD_W);
    localparam int CW = $clog2(NUM_WORDS + 1);
    state_t state, state_nx;
    logic [CW-1:0] word_cnt;
    logic last_q, accept, commit, shift_en, shift_done, full;
    logic [NoConfigBits-1:0] shadow;
    assign accept       = cfg_ready && cfg_valid && !cfg_start;
    assign commit       = state == COMMIT && !cfg_start;
    assign shift_en     = state == SHIFT && !cfg_start;
    assign full         = word_cnt == CW'(NUM_WORDS);
    assign ConfigBits_N = ~ConfigBits;
    always_comb begin
        cfg_ready = state == LOAD;
        busy      = state inside {LOAD, SHIFT, COMMIT};
        err       = state == ERR;
        state_nx  = cfg_start ? LOAD :
                    state == LOAD   ? (accept ? SHIFT : LOAD) :
                    state == SHIFT  ? (!shift_done ? SHIFT :
                                       (last_q && full) ? COMMIT :
                                       (last_q || full) ? ERR : LOAD) :
                    state == COMMIT ? IDLE : state;
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            word_cnt   <= '0;
            last_q     <= 1'b0;
            ConfigBits <= '0;
            done       <= 1'b0;
        end else begin
            state    <= state_nx;
            word_cnt <= cfg_start ? '0 : accept ? word_cnt + 1'b1 : word_cnt;
            if (accept) last_q <= cfg_last;
            if (commit) ConfigBits <= shadow;
            done <= commit;
        end
    end
    ctrl_io_cfg_shifter #(.NoConfigBits(NoConfigBits), .WORD_W(WORD_W)) u_shifter (
        .CLK        (CLK),
        .resetn     (resetn),
        .clear      (cfg_start),
        .load       (accept),
        .shift_en   (shift_en),
        .word       (cfg_data),
        .shadow     (shadow),
        .shift_done (shift_done)
    );
endmodule

// File: tb/tb_ctrl_io_config_loader.sv
// tb_ctrl_io_config_loader: directed frames checked against a word-level behavioural model
module tb_ctrl_io_config_loader;
    logic        CLK = 1'b0, resetn = 1'b1, cfg_start = 1'b0, cfg_valid = 1'b0, cfg_last = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_ready, busy, done, err;
    logic [11:0] ConfigBits, ConfigBits_N;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
    int a0, n0;
    int m_phase = 0, m_left = 0, m_n = 0, m_frame = 0, m_cfg = 0;
    logic m_last = 1'b0, m_done = 1'b0;

    ctrl_io_config_loader dut (
        .CLK(CLK), .resetn(resetn), .cfg_start(cfg_start), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
        .ConfigBits(ConfigBits), .ConfigBits_N(ConfigBits_N),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Phases: 0 idle, 1 awaiting word, 2 shifting, 3 commit, 4 error; frame kept as whole words
    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_phase <= 0; m_left <= 0; m_n <= 0; m_frame <= 0; m_cfg <= 0;
            m_last <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= m_phase == 3 && !cfg_start;
            if (cfg_start) begin
                m_phase <= 1; m_n <= 0; m_frame <= 0;
            end else if (m_phase == 1 && cfg_valid) begin
                m_frame <= (m_frame * 256 + int'(cfg_data)) % 65536;
                m_n <= m_n + 1; m_last <= cfg_last; m_phase <= 2; m_left <= 8;
            end else if (m_phase == 2) begin
                m_left <= m_left - 1;
                if (m_left == 1)
                    m_phase <= (m_last && m_n == 2) ? 3 : (m_last || m_n == 2) ? 4 : 1;
            end else if (m_phase == 3) begin
                m_cfg <= m_frame % 4096;
                m_phase <= 0;
            end
        end
    end

    always @(posedge CLK) begin
        if (resetn && cfg_valid && cfg_ready && !cfg_start) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        check("cfg_ready", cfg_ready, m_phase == 1);
        check("busy", busy, m_phase >= 1 && m_phase <= 3);
        check("err", err, m_phase == 4);
        check("done", done, m_done);
        check("ConfigBits", ConfigBits, m_cfg);
        check("ConfigBits_N", ConfigBits_N, ~m_cfg & 32'hfff);
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last, input logic hold);
        logic got;
        got = 1'b0;
        cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
        for (int i = 0; i < 60 && !got; i++) begin
            got = cfg_ready;
            tick();
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) cfg_valid = 1'b0;
    endtask

    initial begin
        #1 resetn = 1'b0;
        repeat (3) tick();
        check("rst_cfg", ConfigBits, 12'h000);
        check("rst_cfg_n", ConfigBits_N, 12'hfff);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        resetn = 1'b1;
        tick();

        start();
        send_word(8'h0A, 1'b0, 1'b0);
        a0 = acc_cyc;
        check("ready_in_shift", cfg_ready, 1'b0);
        send_word(8'hBC, 1'b1, 1'b0);
        repeat (12) tick();
        check("normal_cfg", ConfigBits, 12'hABC);
        check("normal_cfg_n", ConfigBits_N, 12'h543);
        check("normal_done_cnt", done_cnt, 1);
        check("normal_done_lat", done_cyc - a0, 19);

        start();
        send_word(8'h0F, 1'b1, 1'b0);
        repeat (12) tick();
        check("early_err", err, 1'b1);
        check("early_cfg", ConfigBits, 12'hABC);
        check("early_no_done", done_cnt, 1);
        start();
        check("early_err_clr", err, 1'b0);

        send_word(8'h01, 1'b0, 1'b0);
        send_word(8'h23, 1'b0, 1'b0);
        repeat (12) tick();
        check("missing_err", err, 1'b1);
        check("missing_cfg", ConfigBits, 12'hABC);

        start();
        send_word(8'hFF, 1'b0, 1'b0);
        repeat (3) tick();
        start();
        send_word(8'h00, 1'b0, 1'b0);
        send_word(8'h05, 1'b1, 1'b0);
        repeat (12) tick();
        check("abort_cfg", ConfigBits, 12'h005);
        check("abort_cfg_n", ConfigBits_N, 12'hFFA);
        check("abort_done_cnt", done_cnt, 2);

        n0 = acc_cnt;
        start();
        send_word(8'h12, 1'b0, 1'b1);
        send_word(8'h34, 1'b0, 1'b1);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        check("midrst_cfg", ConfigBits, 12'h000);
        check("midrst_cfg_n", ConfigBits_N, 12'hFFF);
        resetn = 1'b1;
        repeat (20) tick();
        check("bp_accepts", acc_cnt - n0, 2);
        check("midrst_idle_busy", busy, 1'b0);
        check("midrst_idle_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_io_config_loader.md
Name: ctrl_io_config_loader

Overview:
- Configuration controller for the ctrl_IO tile switch matrix.
- Accepts a configuration frame as a stream of words over a valid/ready handshake and shifts it bit-serially into a shadow shift register.
- Checks the frame length, then commits the frame atomically to the ConfigBits/ConfigBits_N buses that drive the tile's mux selects.
- The active configuration never shows a partially loaded frame.

Parameters:
- NoConfigBits, 12: width of the configuration bus driven into the switch matrix.
- WORD_W, 8: width of one input configuration word.
- NUM_WORDS, ceil(NoConfigBits/WORD_W): words per frame. Derived; not overridable.

Ports:
- CLK  in  1: the single clock; all state updates on the rising edge.
- resetn  in  1: asynchronous, active-low reset.
- cfg_start  in  1: one-cycle pulse; begins a new frame.
- cfg_data  in  WORD_W: configuration word, MSB shifted first.
- cfg_valid  in  1: cfg_data/cfg_last are valid.
- cfg_last  in  1: qualifies the final word of a frame.
- cfg_ready  out  1: loader can accept a word this cycle.
- ConfigBits  out  NoConfigBits: active configuration, true polarity.
- ConfigBits_N  out  NoConfigBits: bitwise complement of ConfigBits, always.
- busy  out  1: high in LOAD, SHIFT and COMMIT.
- done  out  1: one-cycle pulse on commit.
- err  out  1: sticky frame-length error.

Behaviour:
- Reset (async assert, sync release):
  - ConfigBits = 0, ConfigBits_N = all ones; every mux selects input 0 and the tristate control selects GND.
  - Shadow = 0, counters = 0, state = IDLE.
  - cfg_ready = 0, busy = 0, done = 0, err = 0.
- States: IDLE, LOAD, SHIFT, COMMIT, ERR.
- IDLE: cfg_ready = 0. cfg_start -> LOAD; shadow, word counter and err are cleared.
- LOAD: cfg_ready = 1. A transfer occurs when cfg_valid and cfg_ready are both high.
  - The accepted word is latched, the word counter increments, cfg_last is recorded, and the state goes to SHIFT.
- SHIFT: cfg_ready = 0; runs exactly WORD_W cycles.
  - Each cycle: shadow <= {shadow[NoConfigBits-2:0], word_msb}, then the latched word shifts left.
  - Bits shifted out of the top of the shadow are discarded.
  - After the WORD_W-th shift:
    - recorded last and count == NUM_WORDS -> COMMIT.
    - recorded last and count < NUM_WORDS -> ERR.
    - not last and count == NUM_WORDS -> ERR.
    - otherwise -> LOAD.
- Padding: P = NUM_WORDS*WORD_W - NoConfigBits leading bits of the frame are padding and fall off the top. The first real bit ends at ConfigBits[NoConfigBits-1].
- COMMIT: one cycle. ConfigBits <= shadow and ConfigBits_N <= ~shadow at the end of this cycle. done = 1 in the following cycle, coincident with the new value. Next state IDLE.
- ERR: err = 1, held until the next cfg_start. ConfigBits is unchanged. cfg_ready = 0. cfg_start -> LOAD.
- Throughput: WORD_W+1 cycles per word. Commit latency: the last shift cycle + 1.
- cfg_start in any state: abort and restart in LOAD the next cycle. The partial shadow is cleared, the active configuration is untouched, and err is cleared.
- cfg_valid while cfg_ready = 0: ignored. The word must be held by the source; no word is lost or duplicated.
- cfg_start and cfg_valid in the same cycle: cfg_start wins; the word is not accepted.
- Reset mid-frame: all state returns to reset values, including ConfigBits = 0.
- ConfigBits_N equals ~ConfigBits in every cycle, including during reset.

Decomposition:
- Package ctrl_io_cfg_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, COMMIT, ERR);
  - a function computing NUM_WORDS from NoConfigBits and WORD_W.
- Sub-module ctrl_io_cfg_shifter contains:
  - the word latch;
  - the shadow shift register;
  - the WORD_W bit counter, with a shift_done output.
- The FSM, word counter and commit register stay in the top level.

Test Plan (defaults, NoConfigBits=12, WORD_W=8):
- Reset: hold resetn = 0 -> ConfigBits = 0x000, ConfigBits_N = 0xFFF, cfg_ready = 0, busy = 0, err = 0.
- Normal frame: cfg_start, then 0x0A, then 0xBC with last.
  - Required: ConfigBits = 0xABC and ConfigBits_N = 0x543.
  - done pulses once, 19 cycles after the first acceptance.
  - cfg_ready is low during each 8-cycle shift.
- Early last: 0x0F with last on word 1 -> err = 1, no done, ConfigBits keeps its prior value; the next cfg_start clears err.
- Missing last: 0x01, then 0x23 without last -> err = 1, ConfigBits unchanged.
- Abort: cfg_start, 0xFF, cfg_start mid-SHIFT, then 0x00, 0x05 with last -> ConfigBits = 0x005 (the partial frame is discarded).
- Backpressure and reset: hold cfg_valid high continuously with a new word only after each acceptance -> exactly 2 acceptances.
  - Pulse resetn low during the second shift -> ConfigBits = 0x000 and state returns to IDLE.
